fetch_sequencer: RTL and testbench

Fetch-stage controller that sequences the instruction ROM for the five-stage pipeline. It owns the PC, drives the ROM byte address, latches the returned word into the IF/ID register, and honours stall (load-use) and redirect (taken branch) requests from downstream. It detects end-of-program as a run of all-zero words, drains the pipeline and signals completion, keeping cycle and instruction counts for the lab report.

---
 rtl/fetch_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Fetch-stage controller for the five-stage lab pipeline. Owns the PC,
// presents it to the instruction ROM, latches the returned word into the
// IF/ID register, and reacts to stall (load-use) and redirect (taken branch)
// requests. A run of END_NOPS accepted all-zero words marks the end of the
// program. The fetcher then drains for DRAIN_CYCLES bubbles and reports done.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           pulse that begins a run from IDLE or DONE
//   stall           hold PC and IF/ID this cycle
//   redirect        load redirect_pc (word aligned) and squash IF/ID
//   redirect_pc     branch target byte address
//   rom_addr        byte address to the ROM (always equals the PC)
//   rom_inst        ROM word at rom_addr, same cycle
//   id_inst/id_pc4  IF/ID instruction and its PC+4
//   id_valid        IF/ID holds a real fetched word
//   busy/done       run in progress / run finished
//   cycle_cnt       cycles spent in RUN+DRAIN (saturating)
//   fetch_cnt       non-zero words accepted (saturating)

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned END_NOPS     = 4,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] cycle_cnt,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] END_NOPS_C   = 4'(END_NOPS);
  localparam logic [3:0] DRAIN_LAST_C = 4'(DRAIN_CYCLES - 1);

  state_t      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] id_inst_q,   id_inst_d;
  logic [31:0] id_pc4_q,    id_pc4_d;
  logic        id_valid_q,  id_valid_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [3:0]  nop_cnt_q,   nop_cnt_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [3:0]  nop_inc;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  assign nop_inc  = nop_cnt_q + 4'd1;

  // Next-state logic. Within RUN the priority is redirect, then stall,
  // then a normal advance. The word that completes the zero run is still
  // latched into IF/ID on the edge that moves us into DRAIN.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    cycle_cnt_d = cycle_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    nop_cnt_d   = nop_cnt_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          pc_d        = RESET_PC;
          id_inst_d   = 32'd0;
          id_pc4_d    = 32'd0;
          id_valid_d  = 1'b0;
          cycle_cnt_d = 16'd0;
          fetch_cnt_d = 16'd0;
          nop_cnt_d   = 4'd0;
          drain_cnt_d = 4'd0;
        end
      end

      S_RUN: begin
        if (redirect) begin
          pc_d       = redirect_pc & ~32'h0000_0003;
          id_inst_d  = 32'd0;
          id_pc4_d   = 32'd0;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_inst_d  = rom_inst;
          id_pc4_d   = pc_plus4;
          id_valid_d = 1'b1;
          pc_d       = pc_plus4;
          if (rom_inst == 32'd0) begin
            nop_cnt_d = nop_inc;
            if (nop_inc == END_NOPS_C) begin
              state_d     = S_DRAIN;
              drain_cnt_d = 4'd0;
            end
          end else begin
            nop_cnt_d = 4'd0;
            if (fetch_cnt_q != 16'hFFFF) begin
              fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
          end
        end
      end

      S_DRAIN: begin
        id_inst_d  = 32'd0;
        id_valid_d = 1'b0;
        if (drain_cnt_q == DRAIN_LAST_C) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every RUN/DRAIN cycle counts, stalls and redirects included.
    if ((state_q == S_RUN || state_q == S_DRAIN) && cycle_cnt_q != 16'hFFFF) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
  end

  assign busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      id_inst_q   <= 32'd0;
      id_pc4_q    <= 32'd0;
      id_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= 16'd0;
      fetch_cnt_q <= 16'd0;
      nop_cnt_q   <= 4'd0;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      nop_cnt_q   <= nop_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign rom_addr  = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cycle_cnt_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer with a small combinational ROM.
// Each step drives inputs, pushes the IF/ID / address / status values the
// step should produce, and pops them for comparison one edge later.

module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        chk_pc4;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        busy;
  logic        done;
  logic [15:0] cycle_cnt;
  logic [15:0] fetch_cnt;

  logic [31:0] rom [0:63];
  exp_t        sb [$];
  int          total_cnt;
  int          bad_cnt;
  int          step_no;

  fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .END_NOPS    (4),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst),
    .id_inst    (id_inst),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .busy       (busy),
    .done       (done),
    .cycle_cnt  (cycle_cnt),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM; anything outside the 64-word image reads as zero.
  assign rom_inst = (rom_addr < 32'd256) ? rom[rom_addr[7:2]] : 32'd0;

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc4,
                              input logic valid, input logic [31:0] addr,
                              input logic bsy, input logic dn, input logic chk);
    exp_t e;
    e.inst    = inst;
    e.pc4     = pc4;
    e.valid   = valid;
    e.addr    = addr;
    e.busy    = bsy;
    e.done    = dn;
    e.chk_pc4 = chk;
    return e;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) else begin
      bad_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops the oldest expectation and compares it against the DUT outputs.
  task automatic checkOutput();
    exp_t  e;
    string s;
    s = $sformatf("step%0d", step_no);
    if (sb.size() == 0) begin
      check32({s, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check32({s, "_id_inst"},  id_inst,          e.inst);
      if (e.chk_pc4) check32({s, "_id_pc4"}, id_pc4, e.pc4);
      check32({s, "_id_valid"}, {31'd0, id_valid}, {31'd0, e.valid});
      check32({s, "_rom_addr"}, rom_addr,         e.addr);
      check32({s, "_busy"},     {31'd0, busy},     {31'd0, e.busy});
      check32({s, "_done"},     {31'd0, done},     {31'd0, e.done});
    end
    step_no++;
  endtask

  // Drives one cycle of inputs, records what the next edge should produce,
  // then samples 1 time unit after that edge.
  task automatic applyStimulus(input logic st, input logic sl, input logic rd,
                               input logic [31:0] rpc, input exp_t e);
    sb.push_back(e);
    start       = st;
    stall       = sl;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
    start       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    checkOutput();
  endtask

  task automatic advanceWords(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0,
                    mk(rom[i], 32'(4 * (i + 1)), 1'b1, 32'(4 * (i + 1)), 1'b1, 1'b0, 1'b1));
    end
  endtask

  // Four drain bubbles; start_at selects a step that also pulses start.
  task automatic drainSteps(input int start_at);
    for (int j = 0; j < 4; j++) begin
      applyStimulus((j == start_at), 1'b1, 1'b1, 32'h0000_0040,
                    mk(32'd0, 32'd0, 1'b0, 32'h30, (j < 3), (j == 3), 1'b0));
    end
  endtask

  task automatic startRun();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0,
                  mk(32'd0, 32'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1));
  endtask

  initial begin
    total_cnt   = 0;
    bad_cnt     = 0;
    step_no     = 0;
    start       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    rst_n       = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    rom[1] = 32'h0010_0443;
    rom[2] = 32'h0010_0421;
    rom[3] = 32'h00a0_0513;
    rom[4] = 32'h1400_2828;
    rom[5] = 32'h00b0_0593;
    rom[6] = 32'h00c0_0613;
    rom[7] = 32'h00d0_0693;

    // Reset values
    #12;
    check32("rst_id_inst",  id_inst,            32'd0);
    check32("rst_id_pc4",   id_pc4,             32'd0);
    check32("rst_id_valid", {31'd0, id_valid},   32'd0);
    check32("rst_rom_addr", rom_addr,           32'd0);
    check32("rst_busy",     {31'd0, busy},       32'd0);
    check32("rst_done",     {31'd0, done},       32'd0);
    check32("rst_cycle",    {16'd0, cycle_cnt},  32'd0);
    check32("rst_fetch",    {16'd0, fetch_cnt},  32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Run 1: free run to completion
    $display("[TB] free run");
    startRun();
    advanceWords(0, 11);
    drainSteps(-1);
    check32("run1_cycle", {16'd0, cycle_cnt}, 32'd16);
    check32("run1_fetch", {16'd0, fetch_cnt}, 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0,
                  mk(32'd0, 32'd0, 1'b0, 32'h30, 1'b0, 1'b1, 1'b0));
    check32("run1_cycle_frozen", {16'd0, cycle_cnt}, 32'd16);

    // Run 2: start from DONE, stall two cycles, start pulses ignored mid-run
    $display("[TB] stall run");
    startRun();
    check32("run2_cycle_clr", {16'd0, cycle_cnt}, 32'd0);
    check32("run2_fetch_clr", {16'd0, fetch_cnt}, 32'd0);
    advanceWords(0, 2);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0,
                    mk(32'h0010_0421, 32'h0C, 1'b1, 32'h0C, 1'b1, 1'b0, 1'b1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0,
                  mk(rom[3], 32'h10, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1));
    advanceWords(4, 11);
    drainSteps(1);
    check32("run2_cycle", {16'd0, cycle_cnt}, 32'd18);
    check32("run2_fetch", {16'd0, fetch_cnt}, 32'd7);

    // Run 3: redirect alone, then redirect together with stall
    $display("[TB] redirect run");
    startRun();
    advanceWords(0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h13,
                  mk(32'd0, 32'd0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0,
                  mk(32'h1400_2828, 32'h14, 1'b1, 32'h14, 1'b1, 1'b0, 1'b1));
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h06,
                  mk(32'd0, 32'd0, 1'b0, 32'h04, 1'b1, 1'b0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0,
                  mk(32'h0010_0443, 32'h08, 1'b1, 32'h08, 1'b1, 1'b0, 1'b1));
    advanceWords(2, 11);
    drainSteps(-1);
    check32("run3_cycle", {16'd0, cycle_cnt}, 32'd20);
    check32("run3_fetch", {16'd0, fetch_cnt}, 32'd9);

    // Run 4: asynchronous reset after five fetches, then restart
    $display("[TB] reset mid-run");
    startRun();
    advanceWords(0, 4);
    #2 rst_n = 1'b0;
    #1;
    check32("mid_rst_id_inst",  id_inst,           32'd0);
    check32("mid_rst_id_pc4",   id_pc4,            32'd0);
    check32("mid_rst_id_valid", {31'd0, id_valid},  32'd0);
    check32("mid_rst_rom_addr", rom_addr,          32'd0);
    check32("mid_rst_busy",     {31'd0, busy},      32'd0);
    check32("mid_rst_done",     {31'd0, done},      32'd0);
    check32("mid_rst_cycle",    {16'd0, cycle_cnt}, 32'd0);
    check32("mid_rst_fetch",    {16'd0, fetch_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    startRun();
    advanceWords(0, 2);
    check32("restart_cycle", {16'd0, cycle_cnt}, 32'd3);
    check32("restart_fetch", {16'd0, fetch_cnt}, 32'd2);

    check32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
